// File: rtl/serial_normalizer_pkg.sv
// Shared constants and state encoding for the serial left-normalizer.
// Optional all-zero flag feature is controlled by SERIAL_NORM_ZERO_EN.
package serial_normalizer_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;
  localparam int LZD_W  = CNT_W;

  // Count reported for an all-zero operand when no zero flag is available
  localparam logic [LZD_W-1:0] LZD_ALL_ZERO = LZD_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/leading_zero_detector_16.sv
// Combinational leading-zero count for a 16-bit word, counted from bit 15.
// All-zero input reports the maximum count and raises all_zero_o.
module leading_zero_detector_16
  import serial_normalizer_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [LZD_W-1:0]  count_o,
  output logic              all_zero_o
);

  // Ascending scan: the highest set bit is written last and wins
  always_comb begin
    count_o = LZD_ALL_ZERO;
    for (int i = 0; i < DATA_W; i++) begin
      if (data_i[i]) count_o = LZD_W'(DATA_W - 1 - i);
    end
  end

  assign all_zero_o = ~|data_i;

endmodule

// File: rtl/serial_normalizer.sv
// Sequential left-normalizer: one shift per cycle until the MSB is aligned.
// Defining SERIAL_NORM_ZERO_EN adds zero_flag and a fast path for zero operands.
//
// state | meaning
// IDLE  | ready, waiting for start
// SHIFT | shifting while counter < lzd_output
// DONE  | done pulse cycle, back to IDLE next
module serial_normalizer
  import serial_normalizer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  lzd_output,
  output logic [CNT_W-1:0]  counter
`ifdef SERIAL_NORM_ZERO_EN
  ,
  output logic              zero_flag
`endif
);

  state_t             state_q;
  logic [DATA_W-1:0]  data_q;
  logic [CNT_W-1:0]   lzd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ready_q;
  logic               done_q;
  logic [LZD_W-1:0]   lzd_raw;
  logic [CNT_W-1:0]   lzd_d;
  logic               all_zero;

  leading_zero_detector_16 u_lzd (
    .data_i     (data_in),
    .count_o    (lzd_raw),
    .all_zero_o (all_zero)
  );

`ifdef SERIAL_NORM_ZERO_EN
  logic zf_q;

  assign lzd_d     = all_zero ? '0 : lzd_raw;
  assign zero_flag = zf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      zf_q <= all_zero;
    end
  end
`else
  assign lzd_d = all_zero ? LZD_ALL_ZERO : lzd_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      lzd_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            data_q  <= data_in;
            lzd_q   <= lzd_d;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q < lzd_q) begin
            data_q <= data_q << 1;
            cnt_q  <= cnt_q + CNT_W'(1);
          end else begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign data_out   = data_q;
  assign lzd_output = lzd_q;
  assign counter    = cnt_q;

endmodule
